pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Decides each cycle whether PC and IF/ID advance (wpcir), whether ID injects a bubble into ID/EX, and whether IF/ID is flushed after a taken control transfer.
- Also decides whether the whole pipeline freezes for a slow data-memory access.
- Tracks memory-wait time with a timeout FSM and keeps saturating stall and flush statistics counters.

Parameters:
- DELAY_SLOT, 1: 1 = branch delay slot architected, so no flush; 0 = flush IF/ID on a taken branch or jump.
- TIMEOUT, 64: MEMWAIT cycles before the error state; legal range 2..65535.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ewreg  in  1  EX-stage instruction writes the register file.
- em2reg  in  1  EX-stage instruction is a load.
- ern  in  5  EX-stage destination register.
- pcsource  in  2  next-PC select from the CU; nonzero means a taken branch or jump.
- mem_req  in  1  MEM stage performs a data access this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- wpcir  out  1  1 = PC and IF/ID load.
- id_bubble  out  1  1 = force ID/EX control signals to zero.
- ifid_flush  out  1  1 = IF/ID loads a NOP.
- pipe_hold  out  1  1 = freeze PC and all pipeline registers.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles with wpcir = 0, saturating.
- flush_cnt  out  CNT_W  cycles with ifid_flush = 1, saturating.

Behaviour:
- Reset (synchronous, active-high) clears:
  - state to RUN; wait_cnt = 0; mem_err = 0; stall_cnt = 0; flush_cnt = 0.
  - While reset is high, outputs are wpcir = 0, id_bubble = 1, ifid_flush = 0, pipe_hold = 0.
  - Reset asserted mid-MEMWAIT or in ERR returns to RUN on the next edge.
- Combinational hazard terms:
  - memwait = mem_req & ~mem_ready.
  - lduse = ewreg & em2reg & (ern != 0) & ((id_use_rs & ern == id_rs) | (id_use_rt & ern == id_rt)).
  - taken = (pcsource != 2'b00).
- Output priority is fixed, highest first: ERR, memwait, lduse, taken.
  - State ERR: pipe_hold = 1, wpcir = 0, id_bubble = 1, ifid_flush = 0.
  - memwait: pipe_hold = 1, wpcir = 0, id_bubble = 0, ifid_flush = 0. The ID/EX contents are held, not bubbled.
  - lduse with no memwait: wpcir = 0, id_bubble = 1, pipe_hold = 0, ifid_flush = 0. The stall lasts exactly 1 cycle because the load moves to MEM on the next edge.
  - taken & ~lduse & ~memwait & DELAY_SLOT == 0: ifid_flush = 1, wpcir = 1. When DELAY_SLOT == 1, ifid_flush is constantly 0.
  - Otherwise: wpcir = 1 and all other outputs 0.
- A branch whose operands are load-use hazarded is resolved on the cycle after the stall; any taken indication during the stall cycle is ignored.
- FSM states: RUN, MEMWAIT, ERR.
  - RUN to MEMWAIT when memwait; wait_cnt is set to 1.
  - In MEMWAIT:
    - mem_ready = 1: go to RUN and clear wait_cnt. The hold releases in that same cycle, so zero-wait accesses cost nothing.
    - mem_ready = 0 and wait_cnt == TIMEOUT-1: go to ERR and set mem_err.
    - Otherwise wait_cnt increments.
  - mem_req dropping while in MEMWAIT returns the FSM to RUN (the request was abandoned).
  - ERR is absorbing until reset; mem_err stays 1.
- Counters:
  - stall_cnt increments on every non-reset cycle with wpcir = 0, including ERR cycles.
  - flush_cnt increments on every cycle with ifid_flush = 1.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- Counters and mem_err are registered; all other outputs are combinational from the current state and inputs, so there is zero added latency.

Test Plan:
1. Load-use: ewreg = 1, em2reg = 1, ern = 5, id_rs = 5, id_use_rs = 1 for one cycle -> exactly 1 cycle with wpcir = 0 and id_bubble = 1; stall_cnt = 1.
2. Register $0 and non-use cases: ern = 0 with id_rs = 0 -> no stall. ern = 7 matching id_rt with id_use_rt = 0 -> no stall.
3. Memory wait: mem_req = 1, mem_ready low for 3 cycles and then high -> pipe_hold = 1 for 3 cycles, released in the ready cycle; stall_cnt = 3; FSM back in RUN.
4. Timeout with TIMEOUT = 4: mem_req = 1, mem_ready = 0 held -> mem_err rises after the 4th hold cycle; pipe_hold stays 1; synchronous reset clears everything.
5. Flush with DELAY_SLOT = 0: pcsource = 2'b01 and no hazard -> ifid_flush = 1 for 1 cycle and flush_cnt = 1. With lduse asserted in the same cycle -> no flush. With DELAY_SLOT = 1 -> ifid_flush is never 1.
6. Saturation with CNT_W = 3: hold lduse for 10 cycles -> stall_cnt sticks at 7. Simultaneous memwait and lduse -> id_bubble = 0 and pipe_hold = 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline. Each cycle it decides
// whether PC and IF/ID advance, whether ID injects a bubble into ID/EX,
// whether IF/ID is flushed after a taken control transfer, and whether the
// whole pipeline freezes while a data-memory access is outstanding. A small
// FSM times memory waits and latches a sticky error on timeout. Two saturating
// counters keep stall and flush statistics.
//
// Parameters:
//   DELAY_SLOT  1 = architected branch delay slot (never flush IF/ID),
//               0 = flush IF/ID on a taken branch/jump
//   TIMEOUT     memory-wait cycles before entering ERR (2..65535)
//   CNT_W       width of the statistics counters
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   id_rs, id_rt            source register fields of the ID instruction
//   id_use_rs, id_use_rt    ID instruction actually reads rs / rt
//   ewreg, em2reg, ern      EX instruction writes RF / is a load / dest reg
//   pcsource                next-PC select; nonzero = taken branch or jump
//   mem_req, mem_ready      MEM-stage access request / completion
//   wpcir                   1 = PC and IF/ID load
//   id_bubble               1 = zero the ID/EX control signals
//   ifid_flush              1 = IF/ID loads a NOP
//   pipe_hold               1 = freeze PC and all pipeline registers
//   mem_err                 sticky memory-timeout error (registered)
//   stall_cnt, flush_cnt    saturating statistics (registered)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int DELAY_SLOT = 1,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       ern,
    input  logic [1:0]       pcsource,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             wpcir,
    output logic             id_bubble,
    output logic             ifid_flush,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    // Flushing is only meaningful without an architected delay slot.
    localparam bit          FLUSH_EN  = (DELAY_SLOT == 0);
    // wait_cnt is 1 on the first MEMWAIT cycle, so hitting TIMEOUT-1 there
    // means TIMEOUT hold cycles have elapsed including the current one.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state;
    logic [15:0] wait_cnt;

    logic memwait;
    logic lduse;
    logic taken;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign memwait = mem_req & ~mem_ready;

    // $0 is never a real producer, so a load targeting it creates no hazard.
    assign lduse = ewreg & em2reg & (ern != 5'd0) &
                   ((id_use_rs & (ern == id_rs)) |
                    (id_use_rt & (ern == id_rt)));

    assign taken = (pcsource != 2'b00);

    // ------------------------------------------------------------------
    // Pipeline control, fixed priority: ERR > memwait > lduse > taken.
    // Purely combinational so a hazard costs no extra cycle. A taken
    // indication during a load-use stall is dropped: the branch is
    // re-resolved after the stall with forwarded operands.
    // ------------------------------------------------------------------
    always_comb begin
        wpcir      = 1'b1;
        id_bubble  = 1'b0;
        ifid_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (reset) begin
            wpcir     = 1'b0;
            id_bubble = 1'b1;
        end else if (state == ERR) begin
            pipe_hold = 1'b1;
            wpcir     = 1'b0;
            id_bubble = 1'b1;
        end else if (memwait) begin
            // Whole pipe frozen: ID/EX keeps its contents, no bubble.
            pipe_hold = 1'b1;
            wpcir     = 1'b0;
        end else if (lduse) begin
            wpcir     = 1'b0;
            id_bubble = 1'b1;
        end else if (taken && FLUSH_EN) begin
            ifid_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait timeout FSM. The hold itself comes from memwait, so the
    // cycle mem_ready arrives is already released; the FSM only tracks time.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memwait) begin
                        state    <= MEMWAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEMWAIT: begin
                    // Covers both completion and an abandoned request.
                    if (!memwait) begin
                        state    <= RUN;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= 16'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!wpcir && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share one stimulus:
// u0 (DELAY_SLOT=0, TIMEOUT=4, CNT_W=3) exercises flush, timeout and
// saturation; u1 (defaults) checks the delay-slot and wide-counter behaviour.
module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ern;
    logic       id_use_rs, id_use_rt, ewreg, em2reg;
    logic [1:0] pcsource;
    logic       mem_req, mem_ready;

    logic        wpcir0, bub0, fl0, hold0, err0;
    logic [2:0]  scnt0, fcnt0;
    logic        wpcir1, bub1, fl1, hold1, err1;
    logic [15:0] scnt1, fcnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.DELAY_SLOT(0), .TIMEOUT(4), .CNT_W(3)) u0 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ewreg(ewreg),
        .em2reg(em2reg), .ern(ern), .pcsource(pcsource), .mem_req(mem_req),
        .mem_ready(mem_ready), .wpcir(wpcir0), .id_bubble(bub0),
        .ifid_flush(fl0), .pipe_hold(hold0), .mem_err(err0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    pipe_hazard_ctrl #(.DELAY_SLOT(1), .TIMEOUT(64), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ewreg(ewreg),
        .em2reg(em2reg), .ern(ern), .pcsource(pcsource), .mem_req(mem_req),
        .mem_ready(mem_ready), .wpcir(wpcir1), .id_bubble(bub1),
        .ifid_flush(fl1), .pipe_hold(hold1), .mem_err(err1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ern = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ewreg = 1'b0; em2reg = 1'b0;
        pcsource = 2'b00; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_lduse();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        // Outputs while reset is high
        chk("rst_wpcir",  wpcir0, 0);
        chk("rst_bubble", bub0,   1);
        chk("rst_flush",  fl0,    0);
        chk("rst_hold",   hold0,  0);
        chk("rst_err",    err0,   0);
        chk("rst_scnt",   scnt0,  0);
        chk("rst_fcnt",   fcnt1,  0);
        reset = 1'b0;
        #1;
        chk("run_wpcir", wpcir0, 1);
        chk("run_bubble", bub0, 0);

        // 1. Load-use: one stall cycle
        set_lduse();
        #1;
        chk("ld_wpcir",  wpcir0, 0);
        chk("ld_bubble", bub0,   1);
        chk("ld_hold",   hold0,  0);
        tick();
        idle();
        #1;
        chk("ld_after_wpcir", wpcir0, 1);
        chk("ld_after_bub",   bub0,   0);
        chk("ld_scnt0", scnt0, 1);
        chk("ld_scnt1", scnt1, 1);

        // 2. $0 and unused-operand cases
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
        #1;
        chk("r0_wpcir", wpcir0, 1);
        tick();
        idle();
        ewreg = 1'b1; em2reg = 1'b1; ern = 5'd7; id_rt = 5'd7; id_use_rt = 1'b0;
        #1;
        chk("nouse_wpcir", wpcir0, 1);
        chk("nouse_bub",   bub0,   0);
        id_use_rt = 1'b1;
        #1;
        chk("rt_use_wpcir", wpcir0, 0);
        id_use_rt = 1'b0;
        tick();
        idle();
        #1;
        chk("nohaz_scnt", scnt1, 1);

        // 3. Memory wait of 3 cycles, released on ready
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_hold",  hold0,  1);
            chk("mw_wpcir", wpcir0, 0);
            chk("mw_bub",   bub0,   0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("mw_rel_hold",  hold0,  0);
        chk("mw_rel_wpcir", wpcir0, 1);
        tick();
        idle();
        #1;
        chk("mw_scnt1", scnt1, 4);
        chk("mw_scnt0", scnt0, 4);
        chk("mw_err",   err0,  0);

        // 4. Timeout on u0 (TIMEOUT=4); u1 keeps waiting
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_hold", hold0, 1);
            chk("to_err_pre", err0, 0);
            tick();
        end
        chk("to_err0", err0, 1);
        chk("to_err1", err1, 0);
        chk("to_hold_err", hold0, 1);
        mem_req = 1'b0;
        #1;
        chk("err_hold",   hold0,  1);
        chk("err_wpcir",  wpcir0, 0);
        chk("err_bub",    bub0,   1);
        chk("u1_release", hold1,  0);
        tick();
        tick();
        chk("err_sticky", err0,  1);
        chk("err_scnt",   scnt0, 6);
        do_reset();
        #1;
        chk("clr_err",  err0,  0);
        chk("clr_scnt", scnt0, 0);
        chk("clr_hold", hold0, 0);
        chk("clr_wpcir", wpcir0, 1);

        // 5. Flush behaviour
        pcsource = 2'b01;
        #1;
        chk("fl_u0",   fl0,    1);
        chk("fl_wpcir", wpcir0, 1);
        chk("fl_u1",   fl1,    0);
        tick();
        idle();
        #1;
        chk("fl_off",   fl0,   0);
        chk("fl_cnt0",  fcnt0, 1);
        chk("fl_cnt1",  fcnt1, 0);
        pcsource = 2'b10;
        set_lduse();
        #1;
        chk("fl_ld_flush", fl0,    0);
        chk("fl_ld_wpcir", wpcir0, 0);
        chk("fl_ld_bub",   bub0,   1);
        tick();
        idle();
        #1;
        chk("fl_ld_cnt", fcnt0, 1);

        // 6. Saturation and memwait-over-lduse priority
        do_reset();
        set_lduse();
        for (int i = 0; i < 10; i++) tick();
        chk("sat_scnt0", scnt0, 7);
        chk("sat_scnt1", scnt1, 10);
        mem_req = 1'b1;
        #1;
        chk("pri_bub",  bub0,  0);
        chk("pri_hold", hold0, 1);
        chk("pri_bub1", bub1,  0);
        tick();
        idle();
        #1;
        chk("sat_hold_scnt0", scnt0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
